left_shift_ctrl: RTL
====================

Name: left_shift_ctrl

Overview:
Sequencer for the serial-input left-shift register. It accepts a parallel word over a valid/ready handshake and streams it MSB-first onto a serial bit line. Each bit is qualified by a shift-enable strobe, so a downstream left_shift stage gains exactly one bit per enabled clock. The block also provides stall, abort and completion signalling to the producer/consumer logic around it.

Parameters:
WIDTH, 4, word length in bits (>= 2)
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  producer offers in_data
in_ready  output  1  block can accept a word
in_data  input  WIDTH  parallel word to serialise
stall  input  1  consumer hold; freezes shifting while high
abort  input  1  cancel the word in flight
ser_out  output  1  serial bit to the shift register data input
shift_en  output  1  consumer must sample ser_out at the next rising edge
bit_idx  output  CNT_W  index of the bit currently on ser_out (0 = MSB)
busy  output  1  word in flight (state != IDLE)
done  output  1  one-cycle pulse after the last bit has shifted

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Internal registers: shreg[WIDTH-1:0], cnt[CNT_W-1:0].
- Reset, asynchronous:
  - State goes to IDLE; shreg and cnt go to 0.
  - While rst is high, outputs are: in_ready=1, ser_out=0, shift_en=0, bit_idx=0, busy=0, done=0.
  - No handshake completes while rst is high.
- All outputs decode combinationally from state, shreg and cnt:
  - in_ready = (state==IDLE)
  - busy = (state!=IDLE)
  - done = (state==DONE)
  - ser_out = shreg[WIDTH-1] in SHIFT, else 0
  - shift_en = (state==SHIFT) & ~stall & ~abort
  - bit_idx = cnt in SHIFT, else 0
- IDLE: on an edge where in_valid is high, load shreg<=in_data, set cnt<=0 and go to SHIFT. Otherwise hold.
- SHIFT, on an edge with shift_en high:
  - shreg <= {shreg[WIDTH-2:0],1'b0}
  - cnt <= cnt+1
  - If cnt==WIDTH-1 before the edge, go to DONE and clear cnt.
- SHIFT with stall high (and abort low): shreg and cnt hold, ser_out stays stable, and shift_en is 0 for as many cycles as stall is high.
- SHIFT with abort high:
  - Abort beats stall.
  - Next edge: state goes to IDLE, shreg and cnt clear, and no done pulse is produced.
  - Bits already shifted downstream are not retracted.
- DONE: done=1 for exactly one cycle, then the block returns unconditionally to IDLE. abort, stall and in_valid are ignored in DONE.
- in_valid and in_data are ignored outside IDLE, so data changes mid-word have no effect.
- abort and stall are ignored in IDLE.
- Latency, with no stall:
  - First bit appears on ser_out in the cycle after the accept edge.
  - done asserts WIDTH cycles after the accept edge.
  - in_ready rises WIDTH+1 cycles after the accept edge.
- Throughput: with in_valid held high, one word per WIDTH+2 cycles.
- Reset mid-word: immediate return to IDLE; the partial word is discarded and there is no done pulse.

Test Plan:
1. WIDTH=4, accept 4'b1011 at edge E0, no stall → ser_out=1,0,1,1 with shift_en=1 and bit_idx=0..3 in the cycles after E0..E3. done=1 only in the cycle after E4. in_ready=1 after E5. A left_shift attached to ser_out reads q=4'b1011 after E4.
2. Back-to-back: in_valid held, in_data=4'hA then 4'h5 → accepts at E0 and E6. ser_out sequence is 1,0,1,0, then 0,1,0,1. in_ready is low between the accepts. Exactly two done pulses.
3. Stall: accept 4'hC, stall high for 2 cycles while bit_idx=1 → ser_out holds 1 with shift_en=0 for both cycles. done is delayed by 2 cycles (asserts 6 cycles after accept). Downstream q still ends at 4'hC.
4. Abort: accept 4'hF, assert abort while bit_idx=2 with stall also high → next cycle busy=0 and in_ready=1, no done, bit_idx=0. A subsequent word 4'h3 then serialises correctly.
5. Async reset: assert rst mid-cycle while bit_idx=1 → outputs go immediately to reset values, no done. After rst deasserts, accept 4'h9 → serialises as 1,0,0,1.
6. Ignore while busy: toggle in_valid and in_data during SHIFT and DONE → no extra accepts, and the serialised word is unchanged.

Source files
------------

// File: rtl/left_shift_ctrl_if.sv
// Word-in / bit-out bus between the producer, left_shift_ctrl and the serial consumer.
// The master drives the word and flow control; the slave answers with the serial stream.
interface left_shift_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             stall;
    logic             abort;
    logic             ser_out;
    logic             shift_en;
    logic [CNT_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, stall, abort,
        input  in_ready, ser_out, shift_en, bit_idx, busy, done
    );

    modport slave (
        input  in_valid, in_data, stall, abort,
        output in_ready, ser_out, shift_en, bit_idx, busy, done
    );
endinterface

// File: rtl/left_shift_ctrl.sv
// Serialises a parallel word MSB-first, one bit per enabled clock, with stall,
// abort and a one-cycle completion pulse.
module left_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    left_shift_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_en;

    // Abort outranks stall, and both only matter while a word is shifting.
    assign shift_en = (state_q == SHIFT) & ~bus.stall & ~bus.abort;
    assign shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
    assign cnt_d    = cnt_q + 1'b1;

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.shift_en = shift_en;
    assign bus.ser_out  = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    assign bus.bit_idx  = (state_q == SHIFT) ? cnt_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg_q <= bus.in_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (shift_en) begin
                        shreg_q <= shreg_d;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule
